// File: rtl/eth_frame_builder_if.sv
// Byte-stream handshake bundle (tdata/tvalid/tready/tlast/tuser) used for both
// the payload input and the frame output of eth_frame_builder.
interface eth_frame_builder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_frame_builder.sv
// Ethernet II frame builder for the MAC transmit path.
// Prepends destination MAC, source MAC and EtherType to a payload byte stream,
// zero-pads short payloads to MIN_PAYLOAD and terminates aborted or oversize
// frames with tuser+tlast so the MAC drops them. Preamble and FCS are left to
// the MAC.
// Optional feature: define ETH_FRAME_BUILDER_SEQ_EN to insert a 32-bit frame
// sequence number (counted as payload) between the header and the payload.
module eth_frame_builder #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int LEN_WIDTH   = 11
) (
  input  logic                tx_clk,
  input  logic                rst,
  input  logic [47:0]         dst_mac,
  input  logic [47:0]         src_mac,
  input  logic [15:0]         ethertype,
  eth_frame_builder_if.slave  s,
  eth_frame_builder_if.master tx,
  output logic                busy,
  output logic [15:0]         frames_sent,
  output logic [15:0]         frames_dropped
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_PAD     = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
`ifdef ETH_FRAME_BUILDER_SEQ_EN
  localparam logic [2:0] ST_SEQ     = 3'd2;
`endif

  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_PAYLOAD);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PAYLOAD);

  logic [2:0]           state;
  logic [3:0]           hdr_idx;
  logic [13:0][7:0]     hdr_q;      // element 13 is the first byte on the wire
  logic [7:0]           hdr_byte;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] cnt_inc;

  logic [7:0] tdata_q;
  logic       tvalid_q;
  logic       tlast_q;
  logic       tuser_q;

  logic load_ok;     // output register can take a new byte this cycle
  logic pay_acc;     // payload byte accepted in PAYLOAD
  logic pay_bad;     // accepted byte aborts the frame
  logic pay_good;    // accepted byte ends a frame that needs no padding
  logic pad_done;    // final pad byte loads this cycle
  logic frame_good;

`ifdef ETH_FRAME_BUILDER_SEQ_EN
  logic [3:0][7:0] seq_num;
  logic [1:0]      seq_idx;
`endif

  // Handshake decode and per-byte frame decisions.
  always_comb begin
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    load_ok    = ~tvalid_q | tx.tready;
    cnt_inc    = cnt + LEN_WIDTH'(1);
    hdr_byte   = hdr_q[4'd13 - hdr_idx];
    pay_acc    = (state == ST_PAYLOAD) & load_ok & s.tvalid;
    pay_bad    = pay_acc & (s.tuser | (cnt_inc > MAX_LEN));
    pay_good   = pay_acc & ~pay_bad & s.tlast & (cnt_inc >= MIN_LEN);
    pad_done   = (state == ST_PAD) & load_ok & (cnt_inc == MIN_LEN);
    frame_good = pay_good | pad_done;
  end

  assign s.tready  = (state == ST_PAYLOAD) ? load_ok : (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign tx.tdata  = tdata_q;
  assign tx.tvalid = tvalid_q;
  assign tx.tlast  = tlast_q;
  assign tx.tuser  = tuser_q;

  // Frame state machine, output register and frame counters.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      // NOTE: hdr_q only carries data, but it is cleared too; it is small and
      // keeps the post-reset state fully deterministic.
      state          <= ST_IDLE;
      hdr_idx        <= '0;
      hdr_q          <= '0;
      cnt            <= '0;
      tdata_q        <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tuser_q        <= 1'b0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // A byte that was accepted (or an empty register) is vacated unless a
      // new byte is loaded below in the same cycle.
      if (load_ok) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end

      if (frame_good) frames_sent    <= frames_sent + 16'd1;
      if (pay_bad)    frames_dropped <= frames_dropped + 16'd1;

      case (state)
        ST_IDLE: begin
          if (s.tvalid) begin
            hdr_q   <= {dst_mac, src_mac, ethertype};
            hdr_idx <= '0;
            state   <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          if (load_ok) begin
            tdata_q  <= hdr_byte;
            tvalid_q <= 1'b1;
            hdr_idx  <= hdr_idx + 4'd1;
            if (hdr_idx == 4'd13) begin
              cnt <= '0;
`ifdef ETH_FRAME_BUILDER_SEQ_EN
              state <= ST_SEQ;
`else
              state <= ST_PAYLOAD;
`endif
            end
          end
        end

`ifdef ETH_FRAME_BUILDER_SEQ_EN
        ST_SEQ: begin
          if (load_ok) begin
            tdata_q  <= seq_num[2'd3 - seq_idx];
            tvalid_q <= 1'b1;
            cnt      <= cnt_inc;
            if (seq_idx == 2'd3) state <= ST_PAYLOAD;
          end
        end
`endif

        ST_PAYLOAD: begin
          if (pay_acc) begin
            tdata_q  <= s.tdata;
            tvalid_q <= 1'b1;
            cnt      <= cnt_inc;
            if (pay_bad) begin
              tlast_q <= 1'b1;
              tuser_q <= 1'b1;
              state   <= s.tlast ? ST_IDLE : ST_DRAIN;
            end else if (pay_good) begin
              tlast_q <= 1'b1;
              state   <= ST_IDLE;
            end else if (s.tlast) begin
              state   <= ST_PAD;
            end
          end
        end

        ST_PAD: begin
          if (load_ok) begin
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b1;
            cnt      <= cnt_inc;
            if (pad_done) begin
              tlast_q <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end

        ST_DRAIN: begin
          if (s.tvalid & s.tlast) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ETH_FRAME_BUILDER_SEQ_EN
  // Sequence number advances only on good frames; byte index walks in SEQ.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      seq_num <= '0;
      seq_idx <= '0;
    end else begin
      if (frame_good) seq_num <= seq_num + 32'd1;
      if (state == ST_HEADER) seq_idx <= '0;
      else if ((state == ST_SEQ) && load_ok) seq_idx <= seq_idx + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_frame_builder.sv
// Self-checking bench for eth_frame_builder: randomized payload stimulus, a
// frame-level reference model feeding an expected-byte queue, and a monitor
// that pops and compares on every accepted output byte.
// Honours ETH_FRAME_BUILDER_SEQ_EN when the design is built with it.
module tb_eth_frame_builder;
  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;
`ifdef ETH_FRAME_BUILDER_SEQ_EN
  localparam int SEQ_LEN = 4;
`else
  localparam int SEQ_LEN = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic        tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        busy;
  logic [15:0] frames_sent;
  logic [15:0] frames_dropped;

  eth_frame_builder_if s_if ();
  eth_frame_builder_if tx_if ();

  eth_frame_builder dut (
    .tx_clk         (tx_clk),
    .rst            (rst),
    .dst_mac        (dst_mac),
    .src_mac        (src_mac),
    .ethertype      (ethertype),
    .s              (s_if),
    .tx             (tx_if),
    .busy           (busy),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
  );

  always #5 tx_clk = ~tx_clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_span = 0;
  bit          rand_ready = 1'b0;
  beat_t       exp_q[$];
  logic [7:0]  pay[$];
  logic [15:0] exp_sent = '0;
  logic [15:0] exp_dropped = '0;
  logic [31:0] seq_model = '0;

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic beat_t mk_beat(input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b.data = d;
    b.last = l;
    b.user = u;
    return b;
  endfunction

  // Reference model: whole expected frame from the payload and the frame rules.
  task automatic model_frame(input int abort_at);
    logic [13:0][7:0] hdr;
    int len, lim, bad_at, pad;
    hdr    = {dst_mac, src_mac, ethertype};
    len    = pay.size();
    lim    = MAX_PAYLOAD - SEQ_LEN;       // user bytes allowed
    bad_at = abort_at;
    if (len > lim && (bad_at == 0 || bad_at > lim + 1)) bad_at = lim + 1;
    for (int i = 0; i < 14; i++) exp_q.push_back(mk_beat(hdr[13 - i], 1'b0, 1'b0));
    for (int i = 0; i < SEQ_LEN; i++) exp_q.push_back(mk_beat(seq_model[31 - 8*i -: 8], 1'b0, 1'b0));
    if (bad_at != 0) begin
      for (int i = 0; i < bad_at - 1; i++) exp_q.push_back(mk_beat(pay[i], 1'b0, 1'b0));
      exp_q.push_back(mk_beat(pay[bad_at - 1], 1'b1, 1'b1));
      exp_dropped++;
    end else begin
      pad = MIN_PAYLOAD - SEQ_LEN - len;
      if (pad < 0) pad = 0;
      for (int i = 0; i < len; i++) exp_q.push_back(mk_beat(pay[i], (pad == 0) && (i == len - 1), 1'b0));
      for (int j = 0; j < pad; j++) exp_q.push_back(mk_beat(8'h00, j == pad - 1, 1'b0));
      exp_sent++;
      seq_model++;
    end
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge tx_clk);
      if (s_if.tvalid && s_if.tready) ok = 1'b1;
      @(posedge tx_clk);
      #1;
      if (ok) return;
    end
  endtask

  // Drives pay[] (or its first stop_after bytes); s_tuser on byte abort_at (1-based).
  task automatic send_frame(input int abort_at, input bit gaps, input int stop_after);
    bit ok;
    int n;
    n = (stop_after < 0) ? pay.size() : stop_after;
    model_frame(abort_at);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_if.tvalid = 1'b0;
          @(posedge tx_clk);
          #1;
        end
      end
      s_if.tdata  = pay[i];
      s_if.tlast  = (i == pay.size() - 1);
      s_if.tuser  = (i + 1 == abort_at);
      s_if.tvalid = 1'b1;
      wait_accept(ok);
      if (!ok) begin
        errors++;
        $display("FAIL s_accept_timeout: byte %0d of %0d not accepted", i, pay.size());
        finish_run();
      end
      if (i == 0) begin
        // Header inputs change mid-frame; the frame must keep the latched ones.
        dst_mac   = {16'h0200, 32'($urandom())};
        src_mac   = {16'h0200, 32'($urandom())};
        ethertype = 16'($urandom());
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy || tx_if.tvalid) && n < 6000) begin
      @(negedge tx_clk);
      n++;
    end
    if (n >= 6000) begin
      errors++;
      $display("FAIL frame_done_timeout: %0d bytes still expected", exp_q.size());
      finish_run();
    end
    check("frames_sent", frames_sent, exp_sent);
    check("frames_dropped", frames_dropped, exp_dropped);
  endtask

  task automatic fill_seq(input int len, input logic [7:0] first);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(first + 8'(i));
  endtask

  task automatic fill_random(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom()));
  endtask

  task automatic set_macs();
    dst_mac   = 48'h02_00_00_00_00_01;
    src_mac   = 48'h02_00_00_00_00_02;
    ethertype = 16'h88B5;
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_tvalid", tx_if.tvalid, 0);
    check("rst_tx_tdata", tx_if.tdata, 0);
    check("rst_tx_tlast", tx_if.tlast, 0);
    check("rst_tx_tuser", tx_if.tuser, 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_busy", busy, 0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_frames_dropped", frames_dropped, 0);
  endtask

  // MAC ready: always high, or ~50% random when rand_ready is set.
  initial begin
    tx_if.tready = 1'b1;
    forever begin
      @(posedge tx_clk);
      #1;
      tx_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: hold-stability while stalled, and scoreboard compare per accepted byte.
  initial begin
    beat_t      e;
    logic [9:0] prev = '0;
    bit         stall_prev = 1'b0;
    int         fpos = 0;
    int         cyc_start = 0;
    forever begin
      @(negedge tx_clk);
      if (rst) begin
        stall_prev = 1'b0;
        fpos       = 0;
      end else begin
        if (stall_prev) begin
          check("hold_tvalid", tx_if.tvalid, 1);
          check("hold_beat", {tx_if.tdata, tx_if.tlast, tx_if.tuser}, prev);
        end
        if (tx_if.tvalid && tx_if.tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_if.tdata);
          end else begin
            e = exp_q.pop_front();
            check("tx_beat", {tx_if.tdata, tx_if.tlast, tx_if.tuser}, e);
          end
          if (fpos == 0) cyc_start = cyc;
          fpos++;
          if (tx_if.tlast) begin
            last_span = cyc - cyc_start + 1;
            fpos      = 0;
          end
        end
        stall_prev = tx_if.tvalid && !tx_if.tready;
        prev       = {tx_if.tdata, tx_if.tlast, tx_if.tuser};
      end
    end
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    int len;
    int ab;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    set_macs();
    repeat (3) @(posedge tx_clk);
    #1 rst = 1'b0;
    @(negedge tx_clk);
    check_reset_outputs();

    // 60-byte payload, full throughput: 74 bytes with no gaps.
    set_macs();
    fill_seq(60, 8'h00);
    send_frame(0, 1'b0, -1);
    wait_done();
    check("span_60_no_gaps", last_span, 74 + SEQ_LEN);

    // 10-byte payload: padded to the minimum.
    set_macs();
    fill_seq(10, 8'hA0);
    send_frame(0, 1'b0, -1);
    wait_done();
    check("span_10_padded", last_span, 60);

    // Oversize: 1510 bytes, cut at MAX+1 and the rest drained; then a 46-byte frame.
    fill_random(1510);
    send_frame(0, 1'b0, -1);
    wait_done();
    fill_random(46);
    send_frame(0, 1'b0, -1);
    wait_done();

    // Exactly at the boundaries: 1500 user bytes, 45 bytes (one pad byte).
    rand_ready = 1'b1;
    fill_random(1500);
    send_frame(0, 1'b1, -1);
    wait_done();
    fill_random(45);
    send_frame(0, 1'b1, -1);
    wait_done();

    // Abort on payload byte 5 without tlast, then drain.
    rand_ready = 1'b0;
    fill_random(20);
    send_frame(5, 1'b0, -1);
    wait_done();

    // 100-byte frame under random MAC back-pressure.
    rand_ready = 1'b1;
    fill_random(100);
    send_frame(0, 1'b0, -1);
    wait_done();

    // Reset pulse mid-payload.
    fill_random(100);
    send_frame(0, 1'b0, 30);
    rst = 1'b1;
    @(posedge tx_clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_sent    = '0;
    exp_dropped = '0;
    seq_model   = '0;
    @(negedge tx_clk);
    check_reset_outputs();

    // Three good frames after reset (sequence numbers 0, 1, 2 when enabled).
    for (int f = 0; f < 3; f++) begin
      fill_random($urandom_range(1, 80));
      send_frame(0, 1'b1, -1);
      wait_done();
    end

    // Random frames: lengths, aborts, back-pressure and input gaps.
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 120);
      ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len) : 0;
      fill_random(len);
      send_frame(ab, 1'b1, -1);
      wait_done();
    end

    finish_run();
  end

endmodule
